rr_mux_reg: RTL and testbench

RR_MUX_REG -- requirements
Module: rr_mux_reg

---
 rtl/rr_mux_reg.sv | 78 +++++++
 tb/tb_rr_mux_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel arbitrating multiplexer with a single registered
// output stage. Grants one valid channel per cycle, either round-robin from a
// rotating pointer or fixed lowest-index priority, and loads the chosen word
// into a valid/ready output register that sustains one word per cycle.
module rr_mux_reg #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out,
  output logic [SW-1:0]        out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Channel visited at step k of the search. Fixed priority scans from 0;
  // round-robin scans from the pointer and wraps at N so non-power-of-two
  // channel counts never produce an index past the last channel.
  function automatic int scan_idx(input logic m, input logic [SW-1:0] p, input int k);
    int s;
    s = m ? k : int'(p) + k;
    if (s >= N) s = s - N;
    return s;
  endfunction

  // Pointer advance past the granted channel, wrapping N-1 back to 0.
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] g);
    if (int'(g) == N - 1) return '0;
    else                  return g + 1'b1;
  endfunction

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    grant_p0;
  logic [WIDTH-1:0] data_p0;
  logic             open_p0;
  logic             take_p0;

  // ---- stage p0: combinational grant and input-side handshake ----
  // Search from the last step down so the earliest step in scan order wins.
  always_comb begin
    grant_p0 = '0;
    data_p0  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[scan_idx(mode, ptr, k)]) begin
        grant_p0 = SW'(scan_idx(mode, ptr, k));
        data_p0  = in[scan_idx(mode, ptr, k)*WIDTH +: WIDTH];
      end
    end
  end

  assign open_p0  = !out_valid || out_ready;
  assign take_p0  = open_p0 && (|in_valid) && !rst;
  assign in_ready = take_p0 ? (N'(1) << grant_p0) : '0;

  // ---- stage p1: output register, reloads on accept, drains on consume ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take_p0) begin
      out_valid <= 1'b1;
      out       <= data_p0;
      out_sel   <= grant_p0;
      ptr       <= wrap_inc(grant_p0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: table-driven per-cycle vectors with a scoreboard queue of
// expected output words, plus hand-written reset and backpressure sequences.
module tb_rr_mux_reg;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [N*WIDTH-1:0] in;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out;
  logic [SW-1:0]      out_sel;
  logic               out_valid;
  logic               out_ready;

  rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in(in), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    sel;
  } exp_t;

  typedef struct {
    bit         rst;
    bit         mode;
    logic [3:0] iv;
    bit         ordy;
    bit         exp_ov;
    logic [3:0] exp_ir;
  } vec_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] chan [N];
  vec_t             vecs [23];
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // One clock: drive on the falling edge, check handshake and the held word
  // just after, update the scoreboard; the state changes on the next rise.
  task automatic cycle(input bit r, input bit m, input logic [3:0] iv, input bit ordy,
                       input bit exp_ov, input logic [3:0] exp_ir);
    exp_t e;
    @(negedge clk);
    rst       = r;
    mode      = m;
    in_valid  = iv;
    out_ready = ordy;
    in        = {chan[3], chan[2], chan[1], chan[0]};
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    if (r) begin
      sb.delete();
    end else begin
      if (exp_ov && ordy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got empty queue expected a word");
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out), 32'(e.data));
          check("out_sel", 32'(out_sel), 32'(e.sel));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (exp_ir[i]) begin
          e.data = chan[i];
          e.sel  = SW'(i);
          sb.push_back(e);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) chan[i] = 16'h1111 * 16'(i + 1);

    //        rst mode iv       ordy ov ir
    vecs[0]  = '{0, 0, 4'b1111, 1, 0, 4'b0001};
    vecs[1]  = '{0, 0, 4'b1111, 1, 1, 4'b0010};
    vecs[2]  = '{0, 0, 4'b1111, 1, 1, 4'b0100};
    vecs[3]  = '{0, 0, 4'b1111, 1, 1, 4'b1000};
    vecs[4]  = '{0, 0, 4'b1111, 1, 1, 4'b0001};
    vecs[5]  = '{0, 0, 4'b0000, 1, 1, 4'b0000};
    vecs[6]  = '{0, 1, 4'b1010, 1, 0, 4'b0010};
    vecs[7]  = '{0, 1, 4'b1010, 1, 1, 4'b0010};
    vecs[8]  = '{0, 1, 4'b1010, 1, 1, 4'b0010};
    vecs[9]  = '{0, 1, 4'b1010, 1, 1, 4'b0010};
    vecs[10] = '{0, 0, 4'b0000, 1, 1, 4'b0000};
    vecs[11] = '{0, 0, 4'b0100, 1, 0, 4'b0100};
    vecs[12] = '{0, 0, 4'b0101, 1, 1, 4'b0001};
    vecs[13] = '{0, 0, 4'b0101, 1, 1, 4'b0100};
    vecs[14] = '{0, 0, 4'b0101, 1, 1, 4'b0001};
    vecs[15] = '{0, 1, 4'b0110, 1, 1, 4'b0010};
    vecs[16] = '{0, 0, 4'b0110, 1, 1, 4'b0100};
    vecs[17] = '{0, 0, 4'b0110, 1, 1, 4'b0010};
    vecs[18] = '{0, 0, 4'b1111, 0, 1, 4'b0000};
    vecs[19] = '{0, 0, 4'b1111, 0, 1, 4'b0000};
    vecs[20] = '{0, 0, 4'b1111, 1, 1, 4'b0100};
    vecs[21] = '{0, 0, 4'b0000, 1, 1, 4'b0000};
    vecs[22] = '{0, 0, 4'b0000, 0, 0, 4'b0000};

    rst = 1'b1; mode = 1'b0; in_valid = '0; out_ready = 1'b0;
    in  = {chan[3], chan[2], chan[1], chan[0]};
    repeat (2) @(posedge clk);

    // Reset holds everything cleared and refuses input.
    cycle(1, 0, 4'b1111, 0, 0, 4'b0000);
    check("rst_out", 32'(out), 32'h0);
    check("rst_sel", 32'(out_sel), 32'h0);
    // Load a word, then reset while it is held: word discarded.
    cycle(0, 0, 4'b0001, 0, 0, 4'b0001);
    cycle(1, 0, 4'b1111, 0, 1, 4'b0000);
    cycle(0, 0, 4'b0000, 0, 0, 4'b0000);
    check("rst2_out", 32'(out), 32'h0);
    check("rst2_sel", 32'(out_sel), 32'h0);

    // Fairness, fixed priority, wrap/skip, mode switching, brief stall.
    for (int v = 0; v < 23; v++)
      cycle(vecs[v].rst, vecs[v].mode, vecs[v].iv, vecs[v].ordy,
            vecs[v].exp_ov, vecs[v].exp_ir);

    // Backpressure: 0xABCD from channel 2 held for three stalled cycles.
    chan[2] = 16'hABCD;
    cycle(0, 0, 4'b0100, 0, 0, 4'b0100);
    for (int s = 0; s < 3; s++) begin
      cycle(0, 0, 4'b1111, 0, 1, 4'b0000);
      check("bp_out", 32'(out), 32'hABCD);
      check("bp_sel", 32'(out_sel), 32'd2);
    end
    cycle(0, 0, 4'b1111, 1, 1, 4'b1000);
    cycle(0, 0, 4'b0000, 1, 1, 4'b0000);
    chan[2] = 16'h3333;

    // Reset in the middle of a round-robin stream.
    cycle(0, 0, 4'b1111, 1, 0, 4'b0001);
    cycle(0, 0, 4'b1111, 1, 1, 4'b0010);
    cycle(0, 0, 4'b1111, 1, 1, 4'b0100);
    cycle(1, 0, 4'b1111, 1, 1, 4'b0000);
    check("mid_sel", 32'(out_sel), 32'd2);
    cycle(0, 0, 4'b1111, 1, 0, 4'b0001);
    check("mid_rst_out", 32'(out), 32'h0);
    cycle(0, 0, 4'b0000, 1, 1, 4'b0000);
    cycle(0, 0, 4'b0000, 1, 0, 4'b0000);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
